// File: rtl/linear_result_collector.sv
// Turns a stream of signed accumulator results into int8 scores, keeps all M and tracks the argmax.
// Samples are stored on the edge they arrive; rd_data has 1-cycle latency; no backpressure, samples in DONE are dropped.
module linear_result_collector #(
    parameter int ACC_WIDTH = 32,
    parameter int OUT_WIDTH = 8,
    parameter int M         = 8,
    parameter int SHIFT     = 4,
    localparam int IDX_W    = $clog2(M),
    localparam int CNT_W    = $clog2(M + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ACC_WIDTH-1:0] in_data,
    input  logic                 in_valid,
    input  logic                 in_done,
    input  logic [IDX_W-1:0]     rd_addr,
    output logic [OUT_WIDTH-1:0] rd_data,
    output logic [IDX_W-1:0]     class_idx,
    output logic [OUT_WIDTH-1:0] class_score,
    output logic [CNT_W-1:0]     count,
    output logic                 result_valid,
    output logic                 busy,
    output logic                 saturated,
    output logic                 short_vec,
    output logic                 overflow
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic [ACC_WIDTH:0] RND  = (SHIFT > 0) ? ((ACC_WIDTH+1)'(1) << RND_SH) : '0;
    localparam logic [ACC_WIDTH:0] MAXQ = (ACC_WIDTH+1)'((1 << (OUT_WIDTH - 1)) - 1);

    state_t state;
    state_t next_state;

    logic [OUT_WIDTH-1:0] buffer [M];

    logic [ACC_WIDTH:0]   relu;
    logic [ACC_WIDTH:0]   rounded;
    logic [ACC_WIDTH:0]   shifted;
    logic                 clamp;
    logic [OUT_WIDTH-1:0] q;

    logic                 store;
    logic [CNT_W-1:0]     cnt_next;
    logic                 set_short;
    logic                 set_ovf;

    // ReLU, round-half-up shift and clamp, done one bit wider than the input.
    always_comb begin
        relu    = in_data[ACC_WIDTH-1] ? '0 : {1'b0, in_data};
        rounded = relu + RND;
        shifted = rounded >> SHIFT;
        clamp   = (shifted > MAXQ);
        q       = clamp ? MAXQ[OUT_WIDTH-1:0] : shifted[OUT_WIDTH-1:0];
    end

    // A sample coinciding with start belongs to no vector and is dropped.
    assign store    = (state == COLLECT) && in_valid && !start;
    assign cnt_next = count + CNT_W'(store);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        set_short  = 1'b0;
        set_ovf    = 1'b0;
        case (state)
            IDLE: begin
                next_state = IDLE;
            end
            COLLECT: begin
                // in_done is judged against the count that includes a same-cycle sample.
                if (cnt_next == CNT_W'(M)) begin
                    next_state = DONE;
                end else if (in_done) begin
                    next_state = DONE;
                    set_short  = 1'b1;
                end
            end
            DONE: begin
                set_ovf = in_valid;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if (start) begin
            next_state = COLLECT;
            set_short  = 1'b0;
            set_ovf    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < M; i++) begin
                buffer[i] <= '0;
            end
            rd_data     <= '0;
            count       <= '0;
            class_idx   <= '0;
            class_score <= '0;
            saturated   <= 1'b0;
            short_vec   <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            rd_data <= (int'(rd_addr) < M) ? buffer[rd_addr] : '0;
            if (start) begin
                count       <= '0;
                class_idx   <= '0;
                class_score <= '0;
                saturated   <= 1'b0;
                short_vec   <= 1'b0;
                overflow    <= 1'b0;
            end else begin
                if (store) begin
                    buffer[count[IDX_W-1:0]] <= q;
                    count                    <= cnt_next;
                    // Strict greater-than keeps the lowest index on ties.
                    if ((count == '0) || (q > class_score)) begin
                        class_idx   <= count[IDX_W-1:0];
                        class_score <= q;
                    end
                    if (clamp) begin
                        saturated <= 1'b1;
                    end
                end
                if (set_short) begin
                    short_vec <= 1'b1;
                end
                if (set_ovf) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    assign result_valid = (state == DONE);
    assign busy         = (state == COLLECT);

endmodule
